// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the Avalon-MM N:1 arbiter.
//   arb_state_t   : arbiter FSM state
//   ARB_MAX_HOSTS : largest supported NUM_HOSTS, also bounds the round-robin search loop
package avalon_mm_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int unsigned ARB_MAX_HOSTS = 8;

endpackage

// File: rtl/avalon_mm_arbiter_host_id_fifo.sv
// host_id_fifo: synchronous FIFO of host indices, one entry per outstanding read.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data  : enqueue an index (ignored when full)
//   pop, pop_data    : dequeue the head (ignored when empty); pop_data is the current head
//   full, empty      : status
//   count            : number of stored entries
module host_id_fifo
  import avalon_mm_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: round-robin N-host to 1-agent Avalon-MM arbiter with pipelined reads.
// Each transfer takes an IDLE cycle (arbitration) then a GRANT phase in which the granted
// host's request is passed straight through to the agent. Accepted reads record the host
// index in a FIFO so in-order readdatavalid strobes are routed back to the issuer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   host_*                   : packed per-host Avalon-MM manager signals (host i at slice i)
//   host_agent_to_host       : read data broadcast to all hosts
//   agent_*                  : single Avalon-MM agent port
// Optional build macro AVALON_MM_ARBITER_DEBUG_EN adds debug_grant, debug_pending and
// debug_orphan_rdv (sticky readdatavalid-while-nothing-outstanding flag).
module avalon_mm_arbiter
  import avalon_mm_arbiter_pkg::*;
#(
  parameter int unsigned NUM_HOSTS   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_HOSTS*ADDR_W-1:0]     host_address,
  input  logic [NUM_HOSTS*DATA_W/8-1:0]   host_byteenable,
  input  logic [NUM_HOSTS-1:0]            host_read,
  input  logic [NUM_HOSTS-1:0]            host_write,
  input  logic [NUM_HOSTS*DATA_W-1:0]     host_host_to_agent,
  output logic [NUM_HOSTS-1:0]            host_waitrequest,
  output logic [DATA_W-1:0]               host_agent_to_host,
  output logic [NUM_HOSTS-1:0]            host_readdatavalid,
  output logic [ADDR_W-1:0]               agent_address,
  output logic [DATA_W/8-1:0]             agent_byteenable,
  output logic                            agent_read,
  output logic                            agent_write,
  output logic [DATA_W-1:0]               agent_host_to_agent,
  input  logic                            agent_waitrequest,
  input  logic [DATA_W-1:0]               agent_agent_to_host,
  input  logic                            agent_readdatavalid
`ifdef AVALON_MM_ARBITER_DEBUG_EN
  ,
  output logic [$clog2(NUM_HOSTS)-1:0]    debug_grant,
  output logic [$clog2(MAX_PENDING):0]    debug_pending,
  output logic                            debug_orphan_rdv
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_HOSTS);
  localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_t           state_q;
  logic [IDX_W-1:0]     grant_q, ptr_q;
  logic [NUM_HOSTS-1:0] eligible;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [31:0]          g_int;
  logic                 in_grant, g_read, g_write, accept;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0]     fifo_head;
  logic [CNT_W-1:0]     fifo_count;

  // Read+write from one host is a read; reads wait for room in the pending FIFO.
  assign eligible = (host_write & ~host_read) | (host_read & {NUM_HOSTS{~fifo_full}});

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < ARB_MAX_HOSTS; i++) begin
      if (i < NUM_HOSTS && !pick_valid) begin
        idx = 32'(ptr_q) + i;
        if (idx >= NUM_HOSTS) idx = idx - NUM_HOSTS;
        if (eligible[IDX_W'(idx)]) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(idx);
        end
      end
    end
  end

  assign in_grant = (state_q == ARB_GRANT);
  assign g_int    = 32'(grant_q);
  assign g_read   = host_read[grant_q];
  assign g_write  = host_write[grant_q] & ~host_read[grant_q];
  assign accept   = (agent_read | agent_write) & ~agent_waitrequest;

  always_comb begin
    agent_read          = 1'b0;
    agent_write         = 1'b0;
    agent_address       = '0;
    agent_byteenable    = '0;
    agent_host_to_agent = '0;
    host_waitrequest    = '1;
    if (in_grant) begin
      // A read can only reappear as a write-to-read switch; hold it off while full.
      agent_read          = g_read & ~fifo_full;
      agent_write         = g_write;
      agent_address       = host_address[g_int*ADDR_W +: ADDR_W];
      agent_byteenable    = host_byteenable[g_int*BE_W +: BE_W];
      agent_host_to_agent = host_host_to_agent[g_int*DATA_W +: DATA_W];
      host_waitrequest[grant_q] = agent_waitrequest | (g_read & fifo_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            ptr_q   <= (grant_q == IDX_W'(NUM_HOSTS - 1)) ? '0 : grant_q + 1'b1;
            state_q <= ARB_IDLE;
          end else if (!(g_read | g_write)) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign fifo_push = accept & agent_read;
  // Responses with nothing outstanding are dropped.
  assign fifo_pop  = agent_readdatavalid & ~fifo_empty;

  host_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_PENDING)
  ) u_host_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (grant_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    host_readdatavalid = '0;
    if (fifo_pop) host_readdatavalid[fifo_head] = 1'b1;
  end

  assign host_agent_to_host = agent_agent_to_host;

`ifdef AVALON_MM_ARBITER_DEBUG_EN
  logic orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_q <= 1'b0;
    end else if (agent_readdatavalid & fifo_empty) begin
      orphan_q <= 1'b1;
    end
  end

  assign debug_grant      = in_grant ? grant_q : '0;
  assign debug_pending    = fifo_count;
  assign debug_orphan_rdv = orphan_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed self-checking bench for avalon_mm_arbiter (NUM_HOSTS=2, MAX_PENDING=4).
// Inputs change 1 time unit after posedge; outputs are checked on the negedge.
module tb_avalon_mm_arbiter;

  localparam int unsigned NH = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MP = 4;
  localparam int unsigned BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NH*AW-1:0]  host_address;
  logic [NH*BW-1:0]  host_byteenable;
  logic [NH-1:0]     host_read, host_write;
  logic [NH*DW-1:0]  host_host_to_agent;
  logic [NH-1:0]     host_waitrequest;
  logic [DW-1:0]     host_agent_to_host;
  logic [NH-1:0]     host_readdatavalid;
  logic [AW-1:0]     agent_address;
  logic [BW-1:0]     agent_byteenable;
  logic              agent_read, agent_write;
  logic [DW-1:0]     agent_host_to_agent;
  logic              agent_waitrequest;
  logic [DW-1:0]     agent_agent_to_host;
  logic              agent_readdatavalid;
`ifdef AVALON_MM_ARBITER_DEBUG_EN
  logic [$clog2(NH)-1:0] debug_grant;
  logic [$clog2(MP):0]   debug_pending;
  logic                  debug_orphan_rdv;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter #(
    .NUM_HOSTS   (NH),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_PENDING (MP)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .host_address        (host_address),
    .host_byteenable     (host_byteenable),
    .host_read           (host_read),
    .host_write          (host_write),
    .host_host_to_agent  (host_host_to_agent),
    .host_waitrequest    (host_waitrequest),
    .host_agent_to_host  (host_agent_to_host),
    .host_readdatavalid  (host_readdatavalid),
    .agent_address       (agent_address),
    .agent_byteenable    (agent_byteenable),
    .agent_read          (agent_read),
    .agent_write         (agent_write),
    .agent_host_to_agent (agent_host_to_agent),
    .agent_waitrequest   (agent_waitrequest),
    .agent_agent_to_host (agent_agent_to_host),
    .agent_readdatavalid (agent_readdatavalid)
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    ,
    .debug_grant         (debug_grant),
    .debug_pending       (debug_pending),
    .debug_orphan_rdv    (debug_orphan_rdv)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_read = '0;
    host_write = '0;
    agent_waitrequest = 1'b0;
    agent_readdatavalid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0]  wr_pat;
    logic [11:0] rd_pat;
    logic [1:0]  exp_wreq;

    rst = 1'b1;
    host_address = '0;
    host_byteenable = '0;
    host_read = '0;
    host_write = '0;
    host_host_to_agent = '0;
    agent_waitrequest = 1'b0;
    agent_agent_to_host = '0;
    agent_readdatavalid = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_agent_read", agent_read, 0);
    check_eq("rst_agent_write", agent_write, 0);
    check_eq("rst_agent_address", agent_address, 0);
    check_eq("rst_agent_be", agent_byteenable, 0);
    check_eq("rst_agent_wdata", agent_host_to_agent, 0);
    check_eq("rst_waitreq", host_waitrequest, 2'b11);
    check_eq("rst_rdv", host_readdatavalid, 2'b00);
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    check_eq("rst_dbg_pending", debug_pending, 0);
    check_eq("rst_dbg_orphan", debug_orphan_rdv, 0);
`endif

    // Single host read of 0x100
    step();
    host_address[0 +: AW] = 32'h100;
    host_byteenable[0 +: BW] = 4'hF;
    host_read = 2'b01;
    @(negedge clk);
    check_eq("t1_idle_read", agent_read, 0);
    check_eq("t1_idle_wreq", host_waitrequest, 2'b11);
    step();
    @(negedge clk);
    check_eq("t1_grant_read", agent_read, 1);
    check_eq("t1_grant_addr", agent_address, 32'h100);
    check_eq("t1_grant_be", agent_byteenable, 4'hF);
    check_eq("t1_grant_wreq", host_waitrequest, 2'b10);
    step();
    host_read = 2'b00;
    @(negedge clk);
    check_eq("t1_after_read", agent_read, 0);
    step();
    agent_readdatavalid = 1'b1;
    agent_agent_to_host = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("t1_rdv", host_readdatavalid, 2'b01);
    check_eq("t1_rdata", host_agent_to_host, 32'hDEADBEEF);
    step();
    agent_readdatavalid = 1'b0;
    @(negedge clk);
    check_eq("t1_rdv_off", host_readdatavalid, 2'b00);

    // Both hosts writing continuously: grants 0,1,0 with an IDLE bubble between
    do_reset();
    host_address[0 +: AW] = 32'hA0;
    host_address[AW +: AW] = 32'hB0;
    host_write = 2'b11;
    wr_pat = 7'b0101010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_eq($sformatf("t2_write_c%0d", c), agent_write, wr_pat[c]);
      if (c == 1 || c == 5) begin
        check_eq($sformatf("t2_addr_c%0d", c), agent_address, 32'hA0);
        check_eq($sformatf("t2_wreq_c%0d", c), host_waitrequest, 2'b10);
      end else if (c == 3) begin
        check_eq("t2_addr_c3", agent_address, 32'hB0);
        check_eq("t2_wreq_c3", host_waitrequest, 2'b01);
      end else begin
        check_eq($sformatf("t2_wreq_c%0d", c), host_waitrequest, 2'b11);
      end
      step();
    end

    // Host1 write stalled by agent for 3 cycles
    do_reset();
    host_write = 2'b10;
    host_address[AW +: AW] = 32'h40;
    host_byteenable[BW +: BW] = 4'hF;
    host_host_to_agent[DW +: DW] = 32'h12345678;
    agent_waitrequest = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) agent_waitrequest = 1'b0;
      @(negedge clk);
      check_eq($sformatf("t3_write_c%0d", c), agent_write, 1);
      check_eq($sformatf("t3_addr_c%0d", c), agent_address, 32'h40);
      check_eq($sformatf("t3_wdata_c%0d", c), agent_host_to_agent, 32'h12345678);
      check_eq($sformatf("t3_wreq_c%0d", c), host_waitrequest, (c == 3) ? 2'b01 : 2'b11);
      step();
    end
    host_write = 2'b00;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq($sformatf("t3_single_accept_c%0d", c), agent_write, 0);
      step();
    end

    // Five reads with MAX_PENDING=4: fifth waits for the first pop
    do_reset();
    host_write = 2'b00;
    host_read = 2'b11;
    rd_pat = 12'b1000_1010_1010;
    for (int c = 0; c < 12; c++) begin
      agent_readdatavalid = (c == 9);
      @(negedge clk);
      check_eq($sformatf("t4_read_c%0d", c), agent_read, rd_pat[c]);
      if (rd_pat[c]) exp_wreq = (c == 3 || c == 7) ? 2'b01 : 2'b10;
      else exp_wreq = 2'b11;
      check_eq($sformatf("t4_wreq_c%0d", c), host_waitrequest, exp_wreq);
      check_eq($sformatf("t4_rdv_c%0d", c), host_readdatavalid, (c == 9) ? 2'b01 : 2'b00);
`ifdef AVALON_MM_ARBITER_DEBUG_EN
      if (c == 8) check_eq("t4_dbg_full", debug_pending, 4);
`endif
      step();
    end
    host_read = 2'b00;
    for (int c = 0; c < 4; c++) begin
      agent_readdatavalid = 1'b1;
      @(negedge clk);
      check_eq($sformatf("t4_resp%0d", c), host_readdatavalid, c[0] ? 2'b01 : 2'b10);
      check_eq($sformatf("t4_resp_read%0d", c), agent_read, 0);
      step();
    end

    // Response with nothing outstanding is dropped
    agent_readdatavalid = 1'b1;
    @(negedge clk);
    check_eq("t5_orphan_rdv", host_readdatavalid, 2'b00);
    step();
    agent_readdatavalid = 1'b0;
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    @(negedge clk);
    check_eq("t5_dbg_orphan", debug_orphan_rdv, 1);
    step();
    @(negedge clk);
    check_eq("t5_dbg_orphan_sticky", debug_orphan_rdv, 1);
`endif

    // Reset in GRANT with two reads outstanding
    do_reset();
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    @(negedge clk);
    check_eq("t6_dbg_orphan_clr", debug_orphan_rdv, 0);
`endif
    host_read = 2'b11;
    for (int c = 0; c < 5; c++) step();
    @(negedge clk);
    check_eq("t6_in_grant", agent_read, 1);
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    check_eq("t6_dbg_pending2", debug_pending, 2);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    host_read = 2'b00;
    @(negedge clk);
    check_eq("t6_post_rst_read", agent_read, 0);
    check_eq("t6_post_rst_wreq", host_waitrequest, 2'b11);
`ifdef AVALON_MM_ARBITER_DEBUG_EN
    check_eq("t6_dbg_pending0", debug_pending, 0);
`endif
    step();
    for (int c = 0; c < 2; c++) begin
      agent_readdatavalid = 1'b1;
      @(negedge clk);
      check_eq($sformatf("t6_late_resp%0d", c), host_readdatavalid, 2'b00);
      step();
    end
    agent_readdatavalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
